// File: rtl/i2c_target_regs_if.sv
// Bus bundle between the I2C target and its surroundings: the two I2C pad
// lines plus the simple 8-bit register port that the target drives.
interface i2c_target_regs_if;
   logic       sclIn;
   logic       sdaIn;
   logic       sdaOut;
   logic [7:0] regAddr;
   logic [7:0] regWData;
   logic       regWrite;
   logic       regRead;
   logic [7:0] regRData;
   logic       busy;

   // The target side: samples the pads and read data, owns everything else.
   modport slave (
      input  sclIn, sdaIn, regRData,
      output sdaOut, regAddr, regWData, regWrite, regRead, busy
   );

   // The environment side: I2C controller pads plus the register bank.
   modport master (
      output sclIn, sdaIn, regRData,
      input  sdaOut, regAddr, regWData, regWrite, regRead, busy
   );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target answering a single 7-bit address. Write transfers load an
// 8-bit register pointer followed by data bytes; read transfers return
// bytes from the bank at the pointer. The pointer auto-increments after
// every data byte and survives between transfers. SCL is never stretched.
module i2c_target_regs #(
   parameter logic [6:0] ADDRESS    = 7'h42,
   parameter int         FILTER_LEN = 3
) (
   input  logic              clk_i,
   input  logic              reset,
   i2c_target_regs_if.slave  bus
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, WR_PTR, PTR_ACK, WR_DATA, DATA_ACK,
      RD_DATA, RD_ACK, IGNORE
   } stateT;

   stateT            state, stateNext;
   logic [1:0]       sclSync, sdaSync;
   logic             sclFilt, sdaFilt, sclPrev, sdaPrev;
   logic [CNT_W-1:0] sclCnt, sdaCnt;
   logic             sclRise, sclFall, startEv, stopEv;
   logic [2:0]       bitCnt, bitCntNext;
   logic [7:0]       shiftReg, shiftNext, byteNow;
   logic             isRead, isReadNext;
   logic             ackPhase, ackPhaseNext;
   logic             ackGot, ackGotNext;
   logic             sdaOutR, sdaOutNext;
   logic [7:0]       regAddrR, regAddrNext;
   logic [7:0]       regWDataR, regWDataNext;
   logic             regWriteR, regWriteNext;
   logic             busyR, busyNext;
   logic             regReadComb;

   // Bring both pad inputs into the clock domain; idle bus level is high.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         sclSync <= 2'b11;
         sdaSync <= 2'b11;
      end else begin
         sclSync <= {sclSync[0], bus.sclIn};
         sdaSync <= {sdaSync[0], bus.sdaIn};
      end
   end

   // Accept a new SCL level only after it has differed from the current one for FILTER_LEN cycles in a row.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         sclFilt <= 1'b1;
         sclCnt  <= '0;
      end else if (sclSync[1] == sclFilt) begin
         sclCnt <= '0;
      end else if (sclCnt == CNT_MAX) begin
         sclFilt <= sclSync[1];
         sclCnt  <= '0;
      end else begin
         sclCnt <= sclCnt + 1'b1;
      end
   end

   // Same glitch filter for SDA, so a short spike can never fake START or STOP.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         sdaFilt <= 1'b1;
         sdaCnt  <= '0;
      end else if (sdaSync[1] == sdaFilt) begin
         sdaCnt <= '0;
      end else if (sdaCnt == CNT_MAX) begin
         sdaFilt <= sdaSync[1];
         sdaCnt  <= '0;
      end else begin
         sdaCnt <= sdaCnt + 1'b1;
      end
   end

   // Remember last cycle's filtered levels for edge detection.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         sclPrev <= 1'b1;
         sdaPrev <= 1'b1;
      end else begin
         sclPrev <= sclFilt;
         sdaPrev <= sdaFilt;
      end
   end

   assign sclRise = sclFilt & ~sclPrev;
   assign sclFall = ~sclFilt & sclPrev;
   assign startEv = sclFilt & sclPrev & sdaPrev & ~sdaFilt;
   assign stopEv  = sclFilt & sclPrev & ~sdaPrev & sdaFilt;
   assign byteNow = {shiftReg[6:0], sdaFilt};

   // Protocol state and datapath registers; reset releases SDA at once.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         bitCnt    <= '0;
         shiftReg  <= '0;
         isRead    <= 1'b0;
         ackPhase  <= 1'b0;
         ackGot    <= 1'b0;
         sdaOutR   <= 1'b1;
         regAddrR  <= '0;
         regWDataR <= '0;
         regWriteR <= 1'b0;
         busyR     <= 1'b0;
      end else begin
         state     <= stateNext;
         bitCnt    <= bitCntNext;
         shiftReg  <= shiftNext;
         isRead    <= isReadNext;
         ackPhase  <= ackPhaseNext;
         ackGot    <= ackGotNext;
         sdaOutR   <= sdaOutNext;
         regAddrR  <= regAddrNext;
         regWDataR <= regWDataNext;
         regWriteR <= regWriteNext;
         busyR     <= busyNext;
      end
   end

   // Next-state logic; START/STOP win over clock edges, and the pointer bumps the cycle after a write strobe.
   always_comb begin
      stateNext    = state;
      bitCntNext   = bitCnt;
      shiftNext    = shiftReg;
      isReadNext   = isRead;
      ackPhaseNext = ackPhase;
      ackGotNext   = ackGot;
      sdaOutNext   = sdaOutR;
      regAddrNext  = regWriteR ? regAddrR + 8'd1 : regAddrR;
      regWDataNext = regWDataR;
      regWriteNext = 1'b0;
      busyNext     = busyR;
      regReadComb  = 1'b0;

      if (startEv) begin
         stateNext    = ADDR;
         bitCntNext   = '0;
         sdaOutNext   = 1'b1;
         busyNext     = 1'b1;
         ackPhaseNext = 1'b0;
         ackGotNext   = 1'b0;
      end else if (stopEv) begin
         stateNext  = IDLE;
         sdaOutNext = 1'b1;
         busyNext   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               sdaOutNext = 1'b1;
            end
            ADDR, WR_PTR, WR_DATA: begin
               if (sclRise) begin
                  shiftNext  = byteNow;
                  bitCntNext = bitCnt + 3'd1;
                  if (bitCnt == 3'd7) begin
                     ackPhaseNext = 1'b0;
                     if (state == ADDR) begin
                        if (byteNow[7:1] == ADDRESS) begin
                           stateNext  = ADDR_ACK;
                           isReadNext = byteNow[0];
                        end else begin
                           stateNext = IGNORE;
                        end
                     end else if (state == WR_PTR) begin
                        regAddrNext = byteNow;
                        stateNext   = PTR_ACK;
                     end else begin
                        regWDataNext = byteNow;
                        regWriteNext = 1'b1;
                        stateNext    = DATA_ACK;
                     end
                  end
               end
            end
            ADDR_ACK, PTR_ACK, DATA_ACK: begin
               if (sclFall) begin
                  if (!ackPhase) begin
                     sdaOutNext   = 1'b0;
                     ackPhaseNext = 1'b1;
                  end else begin
                     bitCntNext   = '0;
                     ackPhaseNext = 1'b0;
                     if (state == ADDR_ACK && isRead) begin
                        regReadComb = 1'b1;
                        shiftNext   = bus.regRData;
                        sdaOutNext  = bus.regRData[7];
                        stateNext   = RD_DATA;
                     end else begin
                        sdaOutNext = 1'b1;
                        stateNext  = (state == ADDR_ACK) ? WR_PTR : WR_DATA;
                     end
                  end
               end
            end
            RD_DATA: begin
               if (sclFall) begin
                  if (bitCnt == 3'd7) begin
                     sdaOutNext = 1'b1;
                     ackGotNext = 1'b0;
                     stateNext  = RD_ACK;
                  end else begin
                     sdaOutNext = shiftReg[6];
                     shiftNext  = {shiftReg[6:0], 1'b0};
                     bitCntNext = bitCnt + 3'd1;
                  end
               end
            end
            RD_ACK: begin
               if (sclRise && !ackGot) begin
                  regAddrNext = regAddrR + 8'd1;
                  if (sdaFilt) begin
                     stateNext = IGNORE;
                  end else begin
                     ackGotNext = 1'b1;
                  end
               end else if (sclFall && ackGot) begin
                  regReadComb = 1'b1;
                  shiftNext   = bus.regRData;
                  sdaOutNext  = bus.regRData[7];
                  bitCntNext  = '0;
                  ackGotNext  = 1'b0;
                  stateNext   = RD_DATA;
               end
            end
            IGNORE: begin
               sdaOutNext = 1'b1;
            end
            default: begin
               stateNext  = IDLE;
               sdaOutNext = 1'b1;
            end
         endcase
      end
   end

   assign bus.sdaOut   = sdaOutR;
   assign bus.regAddr  = regAddrR;
   assign bus.regWData = regWDataR;
   assign bus.regWrite = regWriteR;
   assign bus.regRead  = regReadComb;
   assign bus.busy     = busyR;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: plays the I2C controller on an open-drain bus
// and models the register bank. Expected writes, read strobes and read
// bytes are queued as stimulus is issued and popped when the target acts.
module tb_i2c_target_regs;

   localparam int Q = 10;

   logic clk;
   logic rstN;
   logic sclCtl;
   logic sdaCtl;
   logic [7:0] bank [256];

   int testsRun  = 0;
   int failCount = 0;
   int writeCount = 0;
   int readCount  = 0;
   int lowCount   = 0;

   logic [15:0] expWrQ[$];
   logic [7:0]  expRdAddrQ[$];
   logic [7:0]  expRdByteQ[$];

   i2c_target_regs_if busIf ();

   i2c_target_regs #(.ADDRESS(7'h42), .FILTER_LEN(3)) dut (
      .clk_i (clk),
      .reset (rstN),
      .bus   (busIf.slave)
   );

   assign busIf.sclIn    = sclCtl;
   assign busIf.sdaIn    = sdaCtl & busIf.sdaOut;
   assign busIf.regRData = bank[busIf.regAddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank model: take writes from the target.
   always @(posedge clk) begin
      if (busIf.regWrite) bank[busIf.regAddr] <= busIf.regWData;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Scoreboard side: strobes from the target are matched against queued expectations.
   always @(negedge clk) begin
      if (busIf.sdaOut === 1'b0) lowCount++;
      if (busIf.regWrite || busIf.regRead)
         checkOutput("strobeExclusive", 32'(busIf.regWrite & busIf.regRead), 32'd0);
      if (busIf.regWrite) begin
         writeCount++;
         checkOutput("wrExpected", 32'(expWrQ.size() != 0), 32'd1);
         if (expWrQ.size() != 0)
            checkOutput("wrAddrData", 32'({busIf.regAddr, busIf.regWData}), 32'(expWrQ.pop_front()));
      end
      if (busIf.regRead) begin
         readCount++;
         checkOutput("rdExpected", 32'(expRdAddrQ.size() != 0), 32'd1);
         if (expRdAddrQ.size() != 0)
            checkOutput("rdAddr", 32'(busIf.regAddr), 32'(expRdAddrQ.pop_front()));
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One controller-driven bit, SDA set mid-way through SCL low.
   task automatic applyStimulus(input logic b);
      waitCycles(Q);
      sdaCtl = b;
      waitCycles(Q);
      sclCtl = 1'b1;
      waitCycles(2 * Q);
      sclCtl = 1'b0;
   endtask

   task automatic i2cStart();
      waitCycles(Q);
      sdaCtl = 1'b1;
      waitCycles(Q);
      sclCtl = 1'b1;
      waitCycles(Q);
      sdaCtl = 1'b0;
      waitCycles(Q);
      sclCtl = 1'b0;
   endtask

   task automatic i2cStop();
      waitCycles(Q);
      sdaCtl = 1'b0;
      waitCycles(Q);
      sclCtl = 1'b1;
      waitCycles(Q);
      sdaCtl = 1'b1;
      waitCycles(Q);
   endtask

   task automatic sendByte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) applyStimulus(b[i]);
      waitCycles(Q);
      sdaCtl = 1'b1;
      waitCycles(Q);
      sclCtl = 1'b1;
      waitCycles(Q);
      ack = busIf.sdaIn;
      waitCycles(Q);
      sclCtl = 1'b0;
   endtask

   task automatic recvByte(output logic [7:0] d, input logic nack);
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         waitCycles(Q);
         sdaCtl = 1'b1;
         waitCycles(Q);
         sclCtl = 1'b1;
         waitCycles(Q);
         d = {d[6:0], busIf.sdaIn};
         waitCycles(Q);
         sclCtl = 1'b0;
      end
      applyStimulus(nack);
   endtask

   logic       ack;
   logic [7:0] data;
   int wrBase, rdBase, lowBase;

   // Directed sequence: reset, write, combined read, mismatch, wrap, glitches, mid-transfer reset.
   initial begin
      sclCtl = 1'b1;
      sdaCtl = 1'b1;
      rstN   = 1'b0;
      for (int i = 0; i < 256; i++) bank[i] = 8'h00;
      bank[8'h20] = 8'h5A;
      bank[8'h21] = 8'h3C;
      waitCycles(3);
      checkOutput("rstSdaOut",   32'(busIf.sdaOut),   32'd1);
      checkOutput("rstRegAddr",  32'(busIf.regAddr),  32'd0);
      checkOutput("rstRegWData", 32'(busIf.regWData), 32'd0);
      checkOutput("rstRegWrite", 32'(busIf.regWrite), 32'd0);
      checkOutput("rstRegRead",  32'(busIf.regRead),  32'd0);
      checkOutput("rstBusy",     32'(busIf.busy),     32'd0);
      rstN = 1'b1;
      waitCycles(5);

      // Register write with two data bytes.
      wrBase = writeCount;
      i2cStart();
      checkOutput("wrBusyStart", 32'(busIf.busy), 32'd1);
      sendByte(8'h84, ack); checkOutput("wrAckAddr", 32'(ack), 32'd0);
      sendByte(8'h10, ack); checkOutput("wrAckPtr",  32'(ack), 32'd0);
      expWrQ.push_back({8'h10, 8'hAB});
      sendByte(8'hAB, ack); checkOutput("wrAckData0", 32'(ack), 32'd0);
      expWrQ.push_back({8'h11, 8'hCD});
      sendByte(8'hCD, ack); checkOutput("wrAckData1", 32'(ack), 32'd0);
      checkOutput("wrBusyBeforeStop", 32'(busIf.busy), 32'd1);
      i2cStop();
      checkOutput("wrBusyAfterStop", 32'(busIf.busy), 32'd0);
      checkOutput("wrRegAddr", 32'(busIf.regAddr), 32'h12);
      checkOutput("wrCount", 32'(writeCount - wrBase), 32'd2);

      // Combined read: pointer write, repeated START, two bytes.
      wrBase = writeCount;
      rdBase = readCount;
      i2cStart();
      sendByte(8'h84, ack); checkOutput("rdAckAddrW", 32'(ack), 32'd0);
      sendByte(8'h20, ack); checkOutput("rdAckPtr",   32'(ack), 32'd0);
      i2cStart();
      expRdAddrQ.push_back(8'h20);
      expRdByteQ.push_back(8'h5A);
      sendByte(8'h85, ack); checkOutput("rdAckAddrR", 32'(ack), 32'd0);
      expRdAddrQ.push_back(8'h21);
      expRdByteQ.push_back(8'h3C);
      recvByte(data, 1'b0);
      checkOutput("rdByte0", 32'(data), 32'(expRdByteQ.pop_front()));
      recvByte(data, 1'b1);
      checkOutput("rdByte1", 32'(data), 32'(expRdByteQ.pop_front()));
      i2cStop();
      checkOutput("rdRegAddr", 32'(busIf.regAddr), 32'h22);
      checkOutput("rdCount", 32'(readCount - rdBase), 32'd2);
      checkOutput("rdNoWrites", 32'(writeCount - wrBase), 32'd0);

      // Address mismatch: no ACK, no strobes, pointer untouched.
      wrBase  = writeCount;
      rdBase  = readCount;
      lowBase = lowCount;
      i2cStart();
      sendByte(8'h86, ack); checkOutput("mmNackAddr", 32'(ack), 32'd1);
      sendByte(8'h55, ack); checkOutput("mmNackData", 32'(ack), 32'd1);
      i2cStop();
      checkOutput("mmSdaNeverLow", 32'(lowCount - lowBase), 32'd0);
      checkOutput("mmNoStrobes", 32'((writeCount - wrBase) + (readCount - rdBase)), 32'd0);
      checkOutput("mmRegAddr", 32'(busIf.regAddr), 32'h22);

      // Pointer wrap from 0xFF to 0x00.
      i2cStart();
      sendByte(8'h84, ack); checkOutput("wrapAckAddr", 32'(ack), 32'd0);
      sendByte(8'hFF, ack); checkOutput("wrapAckPtr",  32'(ack), 32'd0);
      expWrQ.push_back({8'hFF, 8'h01});
      sendByte(8'h01, ack);
      expWrQ.push_back({8'h00, 8'h02});
      sendByte(8'h02, ack); checkOutput("wrapAckData1", 32'(ack), 32'd0);
      i2cStop();
      checkOutput("wrapRegAddr", 32'(busIf.regAddr), 32'h01);

      // One-cycle SDA glitches while SCL is high.
      sdaCtl = 1'b0;
      waitCycles(1);
      sdaCtl = 1'b1;
      waitCycles(2 * Q);
      checkOutput("glitchNoStart", 32'(busIf.busy), 32'd0);
      i2cStart();
      waitCycles(Q);
      sclCtl = 1'b1;
      waitCycles(Q);
      sdaCtl = 1'b1;
      waitCycles(1);
      sdaCtl = 1'b0;
      waitCycles(Q);
      sclCtl = 1'b0;
      waitCycles(Q);
      checkOutput("glitchNoStop", 32'(busIf.busy), 32'd1);
      i2cStop();
      checkOutput("glitchStopBusy", 32'(busIf.busy), 32'd0);

      // Reset pulsed while the target is driving the address ACK.
      i2cStart();
      for (int i = 7; i >= 0; i--) applyStimulus(logic'((8'h84 >> i) & 8'h01));
      waitCycles(Q);
      checkOutput("rstAckDriven", 32'(busIf.sdaOut), 32'd0);
      rstN = 1'b0;
      #1;
      checkOutput("rstAsyncRelease", 32'(busIf.sdaOut), 32'd1);
      checkOutput("rstAsyncBusy", 32'(busIf.busy), 32'd0);
      waitCycles(3);
      rstN = 1'b1;
      sdaCtl = 1'b1;
      waitCycles(Q);
      sclCtl = 1'b1;
      waitCycles(2 * Q);
      i2cStart();
      sendByte(8'h84, ack); checkOutput("postRstAckAddr", 32'(ack), 32'd0);
      sendByte(8'h30, ack); checkOutput("postRstAckPtr",  32'(ack), 32'd0);
      i2cStop();
      checkOutput("postRstRegAddr", 32'(busIf.regAddr), 32'h30);

      waitCycles(5);
      checkOutput("wrQueueDrained", 32'(expWrQ.size()), 32'd0);
      checkOutput("rdQueueDrained", 32'(expRdAddrQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
